led_stream_mux: RTL and testbench
=================================

Name: led_stream_mux

Overview:
- Parametrised N-source LED colour stream selector.
- Successor to the two-way combinational ID-shower/colour-buffer selector. Sits between the pixel sources (id_shower, led_color_buffer, future pattern generators) and the LED serial driver.
- Adds a registered output with a valid/ready handshake, per-frame LED counting, and glitch-free source switching that only takes effect on a frame boundary. A mode change therefore never splits a strip refresh between two sources.

Parameters:
- NUM_SRC, 2, number of input colour streams (≥2).
- COLOR_WIDTH, 8, bits per colour channel.
- NUM_LEDS, 150, pixels per frame (≥2).
- DEFAULT_SRC, 0, source active after reset (<NUM_SRC).
- DRAIN_UNSELECTED, 0:
  - 1: unselected sources see ready=1 and their pixels are discarded.
  - 0: unselected sources are stalled (ready=0).
- Derived:
  - SEL_W = max(1, $clog2(NUM_SRC)).
  - IDX_W = $clog2(NUM_LEDS).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- sel_in  input  SEL_W  requested source; may change any cycle.
- src_color_in  input  NUM_SRC*3*COLOR_WIDTH  packed pixels:
  - Source i occupies [i*3*COLOR_WIDTH +: 3*COLOR_WIDTH].
  - Channel order within a source is {green, red, blue}, green in the MSBs.
- src_valid_in  input  NUM_SRC  per-source pixel valid.
- src_ready_out  output  NUM_SRC  per-source ready.
- green_out  output  COLOR_WIDTH  registered green.
- red_out  output  COLOR_WIDTH  registered red.
- blue_out  output  COLOR_WIDTH  registered blue.
- color_valid_out  output  1  output pixel valid.
- color_ready_in  input  1  downstream ready.
- active_sel_out  output  SEL_W  source currently feeding the frame.
- led_index_out  output  IDX_W  index of the next pixel to be accepted from the source.
- frame_done_out  output  1  one-cycle pulse on output transfer of the last pixel of a frame.
- switch_pending_out  output  1  requested source differs from active source.
- sel_err_out  output  1  one-cycle pulse: sel_in ≥ NUM_SRC was sampled.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - active_sel = req_sel = DEFAULT_SRC.
  - led_index = 0.
  - Output register cleared: colours 0, color_valid_out=0, last flag 0.
  - frame_done_out = 0, sel_err_out = 0.
  - Reset asserted mid-frame discards any in-flight pixel. The next frame after release starts at index 0 from DEFAULT_SRC.
- Request register:
  - Each cycle: if sel_in < NUM_SRC, req_sel ← sel_in. Otherwise req_sel holds and sel_err_out pulses the next cycle.
  - switch_pending_out = (req_sel != active_sel), combinational from registers.
- Input accept (all on active source a):
  - src_ready_out[a] = !color_valid_out || color_ready_in.
  - Other bits = DRAIN_UNSELECTED.
  - Accept = src_valid_in[a] && src_ready_out[a].
- Output register (one entry):
  - On accept, load the colours of source a and last = (led_index == NUM_LEDS-1); set color_valid_out=1.
  - Else if color_ready_in, clear color_valid_out.
  - Colours hold their value while valid && !ready.
- Timing:
  - Latency: source pixel to output is 1 cycle.
  - Sustained throughput: 1 pixel/clk when downstream is always ready.
- Counter:
  - led_index increments on accept.
  - On accept at NUM_LEDS-1 it wraps to 0.
  - At that same edge active_sel ← req_sel (the frame-boundary switch).
  - There is no other path that updates active_sel. Changes to sel_in mid-frame only update req_sel.
- Simultaneous events:
  - If sel_in changes in the same cycle as the last-pixel accept, the switch uses the req_sel value from before that edge. The new request applies at the following boundary.
- frame_done_out:
  - Registered: it pulses in the cycle after an output handshake (color_valid_out && color_ready_in) whose last flag = 1.
- Backpressure: while color_ready_in=0 with valid=1, the active ready is 0 and no counter or selection changes occur.
- active_sel_out and led_index_out are register outputs.

Test Plan:
- Reset, then stream 150 pixels from source 0 with ready=1 → outputs appear 1 cycle later. frame_done_out pulses once, in the cycle after pixel 149 transfers out. led_index_out returns to 0.
- At pixel 40, set sel_in=1 → switch_pending_out=1. Pixels 41..149 still come from source 0. Pixel 150 (the next frame's index 0) comes from source 1 and active_sel_out=1.
- Hold color_ready_in=0 for 5 cycles mid-frame → green/red/blue held stable, src_ready_out[a]=0, led_index_out frozen. After release, no pixel is lost or duplicated (check the sequence by counting).
- sel_in=3 with NUM_SRC=3 → sel_err_out pulses, req_sel unchanged, no switch at the boundary.
- DRAIN_UNSELECTED=1: the unselected source sees ready=1 continuously and none of its data appears on the output. DRAIN_UNSELECTED=0: the unselected ready stays 0.
- Assert rst_in=0 at pixel 77 with valid output → color_valid_out=0 immediately. After release, active_sel_out=DEFAULT_SRC and led_index_out=0.

Source files
------------

// File: rtl/led_stream_mux_if.sv
// Pixel-stream bundle between the colour sources, the stream selector and the LED serial driver.
// The selector uses the slave modport; whoever drives the sources and sinks the output uses the master modport.
interface led_stream_mux_if #(
    parameter int NUM_SRC     = 2,
    parameter int COLOR_WIDTH = 8,
    parameter int NUM_LEDS    = 150
);
    localparam int SEL_W = ($clog2(NUM_SRC) > 1) ? $clog2(NUM_SRC) : 1;
    localparam int IDX_W = $clog2(NUM_LEDS);

    logic [SEL_W-1:0]               sel_in;
    logic [NUM_SRC*3*COLOR_WIDTH-1:0] src_color_in;
    logic [NUM_SRC-1:0]             src_valid_in;
    logic [NUM_SRC-1:0]             src_ready_out;
    logic [COLOR_WIDTH-1:0]         green_out;
    logic [COLOR_WIDTH-1:0]         red_out;
    logic [COLOR_WIDTH-1:0]         blue_out;
    logic                           color_valid_out;
    logic                           color_ready_in;
    logic [SEL_W-1:0]               active_sel_out;
    logic [IDX_W-1:0]               led_index_out;
    logic                           frame_done_out;
    logic                           switch_pending_out;
    logic                           sel_err_out;

    modport slave (
        input  sel_in, src_color_in, src_valid_in, color_ready_in,
        output src_ready_out, green_out, red_out, blue_out, color_valid_out,
               active_sel_out, led_index_out, frame_done_out, switch_pending_out, sel_err_out
    );

    modport master (
        output sel_in, src_color_in, src_valid_in, color_ready_in,
        input  src_ready_out, green_out, red_out, blue_out, color_valid_out,
               active_sel_out, led_index_out, frame_done_out, switch_pending_out, sel_err_out
    );
endinterface

// File: rtl/led_stream_mux.sv
// N-source LED colour stream selector with a one-entry registered output and valid/ready handshake.
// Source switching is deferred to the frame boundary, so a strip refresh always comes from one source.
module led_stream_mux #(
    parameter int NUM_SRC          = 2,
    parameter int COLOR_WIDTH      = 8,
    parameter int NUM_LEDS         = 150,
    parameter int DEFAULT_SRC      = 0,
    parameter bit DRAIN_UNSELECTED = 1'b0
) (
    input  logic            clk_in,
    input  logic            rst_in,
    led_stream_mux_if.slave bus
);
    localparam int SEL_W = ($clog2(NUM_SRC) > 1) ? $clog2(NUM_SRC) : 1;
    localparam int IDX_W = $clog2(NUM_LEDS);
    localparam int PIX_W = 3 * COLOR_WIDTH;
    localparam logic [SEL_W-1:0] DEF_SEL  = SEL_W'(DEFAULT_SRC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);

    logic [SEL_W-1:0]   req_sel_q, req_sel_d;
    logic [SEL_W-1:0]   active_sel_q, active_sel_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic               vld_q, vld_d;
    logic               last_q, last_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               sel_ok;
    logic               act_valid;
    logic               act_ready;
    logic               accept;
    logic [PIX_W-1:0]   act_pix;
    logic [NUM_SRC-1:0] src_rdy;

    always_comb begin
        act_pix   = '0;
        act_valid = 1'b0;
        act_ready = !vld_q || bus.color_ready_in;
        src_rdy   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (active_sel_q == SEL_W'(i)) begin
                act_pix    = bus.src_color_in[i*PIX_W +: PIX_W];
                act_valid  = bus.src_valid_in[i];
                src_rdy[i] = act_ready;
            end else begin
                src_rdy[i] = DRAIN_UNSELECTED;
            end
        end
        accept = act_valid && act_ready;
        sel_ok = int'(bus.sel_in) < NUM_SRC;

        req_sel_d    = sel_ok ? bus.sel_in : req_sel_q;
        err_d        = !sel_ok;
        done_d       = vld_q && bus.color_ready_in && last_q;
        idx_d        = idx_q;
        active_sel_d = active_sel_q;
        pix_d        = pix_q;
        last_d       = last_q;
        vld_d        = vld_q;
        if (accept) begin
            pix_d  = act_pix;
            last_d = (idx_q == LAST_IDX);
            vld_d  = 1'b1;
            // The request registered before this edge wins; a same-cycle sel_in change waits a frame.
            if (idx_q == LAST_IDX) begin
                idx_d        = '0;
                active_sel_d = req_sel_q;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else if (bus.color_ready_in) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            req_sel_q    <= DEF_SEL;
            active_sel_q <= DEF_SEL;
            idx_q        <= '0;
            pix_q        <= '0;
            vld_q        <= 1'b0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            req_sel_q    <= req_sel_d;
            active_sel_q <= active_sel_d;
            idx_q        <= idx_d;
            pix_q        <= pix_d;
            vld_q        <= vld_d;
            last_q       <= last_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.src_ready_out      = src_rdy;
    assign bus.green_out          = pix_q[PIX_W-1 -: COLOR_WIDTH];
    assign bus.red_out            = pix_q[2*COLOR_WIDTH-1 -: COLOR_WIDTH];
    assign bus.blue_out           = pix_q[COLOR_WIDTH-1:0];
    assign bus.color_valid_out    = vld_q;
    assign bus.active_sel_out     = active_sel_q;
    assign bus.led_index_out      = idx_q;
    assign bus.frame_done_out     = done_q;
    assign bus.switch_pending_out = (req_sel_q != active_sel_q);
    assign bus.sel_err_out        = err_q;
endmodule

// File: tb/tb_led_stream_mux.sv
// Self-checking bench for led_stream_mux: directed table, frame/switch/backpressure/reset sequences,
// and a randomized phase against a behavioural model, plus a small draining instance.
module tb_led_stream_mux;
    localparam int NS  = 3;
    localparam int CW  = 8;
    localparam int NL  = 150;
    localparam int DEF = 0;
    localparam int SW  = 2;
    localparam int NLB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    led_stream_mux_if #(.NUM_SRC(NS), .COLOR_WIDTH(CW), .NUM_LEDS(NL)) ifa ();
    led_stream_mux #(.NUM_SRC(NS), .COLOR_WIDTH(CW), .NUM_LEDS(NL), .DEFAULT_SRC(DEF),
                     .DRAIN_UNSELECTED(1'b0)) dut_a (.clk_in(clk), .rst_in(rst_n), .bus(ifa));

    led_stream_mux_if #(.NUM_SRC(2), .COLOR_WIDTH(CW), .NUM_LEDS(NLB)) ifb ();
    led_stream_mux #(.NUM_SRC(2), .COLOR_WIDTH(CW), .NUM_LEDS(NLB), .DEFAULT_SRC(1),
                     .DRAIN_UNSELECTED(1'b1)) dut_b (.clk_in(clk), .rst_in(rst_n), .bus(ifb));

    int n_checks = 0;
    int n_errors = 0;

    // Source side: source i emits {green=i, red/blue = its 16-bit sequence number}.
    int src_cnt[NS];
    int exp_next[NS];

    // Behavioural reference: frame position, selections and the single output slot.
    int          m_req, m_act, m_pos;
    logic        m_vld, m_last, m_done, m_err;
    logic [23:0] m_pix;

    typedef struct {
        int          sel;
        logic [NS-1:0] vld;
        logic        rdy;
        logic        e_vld;
        int          e_idx;
        int          e_act;
        logic        e_pend;
        logic        e_err;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("green", ifa.green_out, m_pix[23:16]);
        chk("red", ifa.red_out, m_pix[15:8]);
        chk("blue", ifa.blue_out, m_pix[7:0]);
        chk("color_valid", ifa.color_valid_out, m_vld);
        chk("active_sel", ifa.active_sel_out, m_act);
        chk("led_index", ifa.led_index_out, m_pos);
        chk("frame_done", ifa.frame_done_out, m_done);
        chk("switch_pending", ifa.switch_pending_out, (m_req != m_act));
        chk("sel_err", ifa.sel_err_out, m_err);
        if (ifb.color_valid_out) chk("b_unselected_data", ifb.green_out, 1);
    endtask

    // One clock: drive at negedge, check combinational ready, advance model, compare after the edge.
    task automatic step(input int sel, input logic [NS-1:0] vld, input logic rdy);
        logic          m_rdy, acc, n_done, n_err;
        logic [NS-1:0] hs;
        int            n_req, s;
        ifa.sel_in         = SW'(sel);
        ifa.src_valid_in   = vld;
        ifa.color_ready_in = rdy;
        for (int i = 0; i < NS; i++) ifa.src_color_in[i*24 +: 24] = {8'(i), 16'(src_cnt[i])};
        #1;
        m_rdy = !m_vld || rdy;
        for (int i = 0; i < NS; i++) begin
            chk("src_ready", ifa.src_ready_out[i], (i == m_act) ? m_rdy : 1'b0);
            hs[i] = vld[i] && ifa.src_ready_out[i];
        end
        chk("b_drain_ready", ifb.src_ready_out[0], 1);
        if (ifa.color_valid_out && rdy) begin
            s = int'(ifa.green_out);
            if (s >= NS) chk("out_source_id", s, 0);
            else begin
                chk("out_sequence", {ifa.red_out, ifa.blue_out}, exp_next[s] & 16'hffff);
                exp_next[s]++;
            end
        end
        acc    = vld[m_act] && m_rdy;
        n_done = m_vld && rdy && m_last;
        n_err  = !(sel < NS);
        n_req  = (sel < NS) ? sel : m_req;
        if (acc) begin
            m_pix  = {8'(m_act), 16'(src_cnt[m_act])};
            m_last = (m_pos == NL - 1);
            m_vld  = 1'b1;
            if (m_pos == NL - 1) begin
                m_pos = 0;
                m_act = m_req;
            end else m_pos++;
        end else if (rdy) m_vld = 1'b0;
        m_req  = n_req;
        m_done = n_done;
        m_err  = n_err;
        @(posedge clk);
        for (int i = 0; i < NS; i++) src_cnt[i] += int'(hs[i]);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_color_valid", ifa.color_valid_out, 0);
        chk("rst_led_index", ifa.led_index_out, 0);
        chk("rst_active_sel", ifa.active_sel_out, DEF);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        m_req  = DEF;
        m_act  = DEF;
        m_pos  = 0;
        m_vld  = 1'b0;
        m_last = 1'b0;
        m_pix  = '0;
        m_done = 1'b0;
        m_err  = 1'b0;
        for (int i = 0; i < NS; i++) exp_next[i] = src_cnt[i];
        compare_all();
        chk("b_rst_active_sel", ifb.active_sel_out, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cur_sel, done_pulses, guard;
        logic [7:0] hg, hr, hb, hidx;

        tbl[0] = '{0, 3'b001, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0};
        tbl[1] = '{3, 3'b000, 1'b1, 1'b0, 1, 0, 1'b0, 1'b1};
        tbl[2] = '{2, 3'b001, 1'b0, 1'b1, 2, 0, 1'b1, 1'b0};
        tbl[3] = '{2, 3'b001, 1'b0, 1'b1, 2, 0, 1'b1, 1'b0};
        tbl[4] = '{0, 3'b001, 1'b1, 1'b1, 3, 0, 1'b0, 1'b0};
        tbl[5] = '{0, 3'b010, 1'b1, 1'b0, 3, 0, 1'b0, 1'b0};

        for (int i = 0; i < NS; i++) begin
            src_cnt[i]  = 100 * (i + 1);
            exp_next[i] = src_cnt[i];
        end
        ifa.sel_in = '0; ifa.src_valid_in = '0; ifa.color_ready_in = 1'b1; ifa.src_color_in = '0;
        ifb.sel_in = 1'b1; ifb.src_valid_in = 2'b11; ifb.color_ready_in = 1'b1;
        ifb.src_color_in = {8'h01, 16'h5a5a, 8'h00, 16'ha5a5};
        #2;
        do_reset();

        for (int k = 0; k < 6; k++) begin
            step(tbl[k].sel, tbl[k].vld, tbl[k].rdy);
            chk("tbl_valid", ifa.color_valid_out, tbl[k].e_vld);
            chk("tbl_index", ifa.led_index_out, tbl[k].e_idx);
            chk("tbl_active", ifa.active_sel_out, tbl[k].e_act);
            chk("tbl_pending", ifa.switch_pending_out, tbl[k].e_pend);
            chk("tbl_err", ifa.sel_err_out, tbl[k].e_err);
        end

        // Full frame from source 0, switch requested at pixel 40, takes effect at the boundary.
        do_reset();
        done_pulses = 0;
        for (int c = 0; c < 156; c++) begin
            step((c >= 40) ? 1 : 0, 3'b111, 1'b1);
            done_pulses += int'(ifa.frame_done_out);
            if (c == 40) chk("pending_after_request", ifa.switch_pending_out, 1);
            if (c == 148) chk("last_frame_pixel_src", ifa.green_out, 0);
            if (c == 149) begin
                chk("wrap_index", ifa.led_index_out, 0);
                chk("switched_at_boundary", ifa.active_sel_out, 1);
            end
            if (c == 150) begin
                chk("done_after_last", ifa.frame_done_out, 1);
                chk("next_frame_src", ifa.green_out, 1);
            end
        end
        chk("frame_done_count", done_pulses, 1);

        // Backpressure: output held, ready low, index frozen.
        hg = ifa.green_out; hr = ifa.red_out; hb = ifa.blue_out; hidx = ifa.led_index_out;
        for (int c = 0; c < 5; c++) begin
            step(1, 3'b111, 1'b0);
            chk("bp_green", ifa.green_out, hg);
            chk("bp_red", ifa.red_out, hr);
            chk("bp_blue", ifa.blue_out, hb);
            chk("bp_index", ifa.led_index_out, hidx);
            chk("bp_src_ready", ifa.src_ready_out[1], 0);
        end
        for (int c = 0; c < 10; c++) step(1, 3'b111, 1'b1);

        // Out-of-range select: error pulse, request kept, no switch at the boundary.
        step(3, 3'b111, 1'b1);
        chk("sel_err_pulse", ifa.sel_err_out, 1);
        chk("sel_err_no_pending", ifa.switch_pending_out, 0);
        step(1, 3'b111, 1'b1);
        chk("sel_err_clears", ifa.sel_err_out, 0);
        guard = 0;
        do begin
            step(3, 3'b111, 1'b1);
            guard++;
        end while (ifa.led_index_out != 0 && guard < 200);
        chk("boundary_reached", guard < 200, 1);
        chk("no_switch_on_bad_sel", ifa.active_sel_out, 1);

        // Reset in the middle of a frame with a valid output pixel.
        guard = 0;
        while (ifa.led_index_out != 77 && guard < 200) begin
            step(1, 3'b111, 1'b1);
            guard++;
        end
        chk("reached_pixel_77", ifa.led_index_out, 77);
        chk("valid_before_reset", ifa.color_valid_out, 1);
        do_reset();
        chk("post_reset_active", ifa.active_sel_out, DEF);
        chk("post_reset_index", ifa.led_index_out, 0);

        // Randomized traffic.
        cur_sel = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) cur_sel = $urandom_range(0, 3);
            step(cur_sel, NS'($urandom_range(0, 7) | (($urandom_range(0, 3) != 0) ? 1 << m_act : 0)),
                 $urandom_range(0, 3) != 0);
            if (c == 1500) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
